// File: rtl/cpu_bus1_master_pkg.sv
// Shared command encodings, bus widths and cache-address helpers for the
// CPU-side cache bus 1 master.
package cpu_bus1_master_pkg;

  localparam int unsigned CACHE_TAG_SIZE    = 10;
  localparam int unsigned CACHE_SET_SIZE    = 5;
  localparam int unsigned CACHE_OFFSET_SIZE = 4;
  localparam int unsigned ADDR1_BUS_SIZE    = 15;
  localparam int unsigned DATA_BUS_SIZE     = 16;
  localparam int unsigned CTR1_BUS_SIZE     = 3;
  localparam int unsigned RESP_TIMEOUT      = 255;

  localparam int unsigned CPU_ADDR_SIZE = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
  localparam int unsigned CPU_DATA_SIZE = 32;
  localparam int unsigned WDOG_SIZE     = $clog2(RESP_TIMEOUT + 1);

  typedef logic [CTR1_BUS_SIZE-1:0] c1_t;

  // C1_RESPONSE shares its code with C1_WRITE32; direction disambiguates.
  localparam c1_t C1_NOP             = 3'd0;
  localparam c1_t C1_READ8           = 3'd1;
  localparam c1_t C1_READ16          = 3'd2;
  localparam c1_t C1_READ32          = 3'd3;
  localparam c1_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_t C1_WRITE8          = 3'd5;
  localparam c1_t C1_WRITE16         = 3'd6;
  localparam c1_t C1_WRITE32         = 3'd7;
  localparam c1_t C1_RESPONSE        = 3'd7;

  typedef struct packed {
    logic [CACHE_TAG_SIZE-1:0]    tag;
    logic [CACHE_SET_SIZE-1:0]    set;
    logic [CACHE_OFFSET_SIZE-1:0] offset;
  } cpu_addr_t;

  // One registered bus phase: drive gates A1/C1, drive && data_en gates D1.
  typedef struct packed {
    logic                      drive;
    logic                      data_en;
    logic [ADDR1_BUS_SIZE-1:0] a1;
    logic [DATA_BUS_SIZE-1:0]  d1;
    c1_t                       c1;
  } bus_drive_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR2,
    ST_WAIT,
    ST_DATA2
  } state_t;

  function automatic cpu_addr_t split_addr(input logic [CPU_ADDR_SIZE-1:0] addr);
    return cpu_addr_t'(addr);
  endfunction

  function automatic logic is_write(input c1_t cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  // Zero-extend the first response word according to the read width.
  function automatic logic [CPU_DATA_SIZE-1:0] first_word(input c1_t cmd,
                                                         input logic [DATA_BUS_SIZE-1:0] d);
    logic [CPU_DATA_SIZE-1:0] r;
    r = '0;
    if (cmd == C1_READ8) r = CPU_DATA_SIZE'(d[7:0]);
    else if (cmd == C1_READ16 || cmd == C1_READ32) r = CPU_DATA_SIZE'(d);
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus1_master_if.sv
// Request/response handshake between the CPU and the bus 1 master.
interface cpu_bus1_master_if;
  import cpu_bus1_master_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  c1_t                      req_cmd;
  logic [CPU_ADDR_SIZE-1:0] req_addr;
  logic [CPU_DATA_SIZE-1:0] req_wdata;
  logic                     rsp_done;
  logic [CPU_DATA_SIZE-1:0] rsp_rdata;
  logic                     rsp_error;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_done, rsp_rdata, rsp_error
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_done, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/cpu_bus1_master_bus1_driver.sv
// Falling-edge registered tristate stage for A1/D1/C1, giving the cache
// half a cycle of setup before its rising-edge sample.
module bus1_driver
  import cpu_bus1_master_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  bus_drive_t                drive,
  inout  wire [ADDR1_BUS_SIZE-1:0]  a1_wire,
  inout  wire [DATA_BUS_SIZE-1:0]   d1_wire,
  inout  wire [CTR1_BUS_SIZE-1:0]   c1_wire
);

  bus_drive_t q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= drive;
  end

  assign a1_wire = q.drive              ? q.a1 : {ADDR1_BUS_SIZE{1'bz}};
  assign c1_wire = q.drive              ? q.c1 : {CTR1_BUS_SIZE{1'bz}};
  assign d1_wire = (q.drive && q.data_en) ? q.d1 : {DATA_BUS_SIZE{1'bz}};

endmodule

// File: rtl/cpu_bus1_master.sv
// CPU-side cache bus 1 master: serialises one request into the command,
// address and data phases, then collects the cache response with a watchdog.
module cpu_bus1_master
  import cpu_bus1_master_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  cpu_bus1_master_if.slave          cpu,
  inout  wire [ADDR1_BUS_SIZE-1:0]  A1_WIRE,
  inout  wire [DATA_BUS_SIZE-1:0]   D1_WIRE,
  inout  wire [CTR1_BUS_SIZE-1:0]   C1_WIRE
);

  state_t                   state;
  c1_t                      cmd_q;
  cpu_addr_t                addr_q;
  logic [CPU_DATA_SIZE-1:0] wdata_q;
  logic [WDOG_SIZE-1:0]     wdog;
  logic                     ready_q;
  logic                     done_q;
  logic                     error_q;
  logic [CPU_DATA_SIZE-1:0] rdata_q;
  bus_drive_t               drive_c;

  assign cpu.req_ready = ready_q;
  assign cpu.rsp_done  = done_q;
  assign cpu.rsp_error = error_q;
  assign cpu.rsp_rdata = rdata_q;

  // Transaction sequencer, response capture and watchdog.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cmd_q   <= C1_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      wdog    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu.req_valid) begin
            if (cpu.req_cmd == C1_NOP) begin
              // Not a bus command: complete immediately with an error.
              done_q  <= 1'b1;
              error_q <= 1'b1;
              rdata_q <= '0;
            end else begin
              cmd_q   <= cpu.req_cmd;
              addr_q  <= split_addr(cpu.req_addr);
              wdata_q <= cpu.req_wdata;
              ready_q <= 1'b0;
              state   <= ST_CMD;
            end
          end
        end
        ST_CMD:   state <= ST_ADDR2;
        ST_ADDR2: state <= ST_WAIT;
        ST_WAIT: begin
          if (C1_WIRE == C1_RESPONSE) begin
            wdog    <= '0;
            rdata_q <= first_word(cmd_q, D1_WIRE);
            if (cmd_q == C1_READ32) begin
              state <= ST_DATA2;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state   <= ST_IDLE;
            end
          end else if (wdog == WDOG_SIZE'(RESP_TIMEOUT - 1)) begin
            wdog    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wdog <= wdog + WDOG_SIZE'(1);
          end
        end
        ST_DATA2: begin
          rdata_q[CPU_DATA_SIZE-1:DATA_BUS_SIZE] <= D1_WIRE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus phase contents; the driver registers them on the falling edge.
  always_comb begin
    drive_c = '0;
    case (state)
      ST_CMD: begin
        drive_c.drive   = 1'b1;
        drive_c.data_en = is_write(cmd_q);
        drive_c.c1      = cmd_q;
        drive_c.a1      = ADDR1_BUS_SIZE'({addr_q.tag, addr_q.set});
        drive_c.d1      = wdata_q[DATA_BUS_SIZE-1:0];
      end
      ST_ADDR2: begin
        drive_c.drive   = 1'b1;
        drive_c.data_en = is_write(cmd_q);
        drive_c.c1      = cmd_q;
        drive_c.a1      = ADDR1_BUS_SIZE'(addr_q.offset);
        drive_c.d1      = (cmd_q == C1_WRITE32) ? wdata_q[CPU_DATA_SIZE-1:DATA_BUS_SIZE]
                                                : wdata_q[DATA_BUS_SIZE-1:0];
      end
      default: drive_c = '0;
    endcase
  end

  bus1_driver u_drv (
    .clk     (CLK),
    .rst_n   (RESET),
    .drive   (drive_c),
    .a1_wire (A1_WIRE),
    .d1_wire (D1_WIRE),
    .c1_wire (C1_WIRE)
  );

endmodule
